// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit-word to 16-bit asynchronous SRAM controller.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WORD_W      = 32;
  localparam int WORD_IDX_W  = SRAM_ADDR_W - 1;

  localparam int unsigned        DEF_WAIT_CYCLES = 5;
  localparam logic [WORD_W-1:0]  DEF_ADDR_BASE   = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // 32-bit word index inside the SRAM; the top address bits wrap modulo the SRAM size.
  function automatic logic [WORD_IDX_W-1:0] sram_word_idx(input logic [WORD_W-1:0] addr,
                                                          input logic [WORD_W-1:0] base);
    return WORD_IDX_W'((addr - base) >> 2);
  endfunction

  function automatic logic addr_out_of_range(input logic [WORD_W-1:0] addr,
                                             input logic [WORD_W-1:0] base);
    return (addr < base) || (((addr - base) >> (SRAM_ADDR_W + 1)) != '0);
  endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// MEM-stage request/response bus between the pipeline (master) and the SRAM controller (slave).
interface sram_mem_controller_if;
  import sram_pkg::*;

  logic              rd_en;
  logic              wr_en;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] write_data;
  logic [WORD_W-1:0] read_data;
  logic              ready;
  logic              addr_err;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready, addr_err
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready, addr_err
  );
endinterface

// File: rtl/sram_wait_counter.sv
// Phase wait counter: counts cycles a half-word phase is held, flags the last one.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  if (WAIT_CYCLES < 2 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("sram_wait_counter: WAIT_CYCLES must be in 2..15");
  end

  localparam logic [3:0] TC_VAL = 4'(WAIT_CYCLES - 1);

  logic [3:0] count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i)   count_d = '0;
    else if (en_i) count_d = count_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/sram_mem_controller.sv
// Splits each 32-bit MEM-stage access into low/high 16-bit SRAM phases, freezing the pipeline via ready.
// Optional range check (addr_err, IDLE->DONE on bad address) is built when SRAM_ADDR_CHECK_EN is defined.
module sram_mem_controller
  import sram_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [WORD_W-1:0] ADDR_BASE   = DEF_ADDR_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_mem_controller_if.slave   bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  state_e state_q, state_d;

  logic                   is_wr_q, is_wr_d;
  logic [WORD_IDX_W-1:0]  word_q, word_d;
  logic [SRAM_DATA_W-1:0] wdata_hi_q, wdata_hi_d;
  logic [WORD_W-1:0]      rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_W-1:0] dq_out_q, dq_out_d;

  logic                   req;
  logic                   range_err;
  logic                   in_phase;
  logic                   cnt_tc;
  logic                   phase_tc;
  logic [WORD_IDX_W-1:0]  req_word;

  assign req      = bus.rd_en | bus.wr_en;
  assign req_word = sram_word_idx(bus.address, ADDR_BASE);
  assign in_phase = (state_q == LO) || (state_q == HI);
  assign phase_tc = in_phase & cnt_tc;

`ifdef SRAM_ADDR_CHECK_EN
  logic addr_err_q;

  assign range_err = addr_out_of_range(bus.address, ADDR_BASE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   addr_err_q <= 1'b0;
    else if (state_q == IDLE && req && range_err) addr_err_q <= 1'b1;
  end

  assign bus.addr_err = addr_err_q;
`else
  assign range_err    = 1'b0;
  assign bus.addr_err = 1'b0;
`endif

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (~in_phase | phase_tc),
    .en_i    (in_phase),
    .tc_o    (cnt_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; DONE never restarts, so a request still held there is the completed one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = range_err ? DONE : LO;
      LO:   if (cnt_tc) state_d = HI;
      HI:   if (cnt_tc) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin/handshake outputs; the write strobe rises on the last phase cycle while address and data hold.
  always_comb begin
    bus.ready  = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (state_q)
      IDLE: bus.ready = ~req;
      LO, HI: begin
        if (is_wr_q) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = cnt_tc;
        end else begin
          sram_oe_n  = 1'b0;
        end
      end
      DONE: bus.ready = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

  // Request is latched on IDLE->LO so later changes on the bus cannot disturb the access.
  always_comb begin
    is_wr_d     = is_wr_q;
    word_d      = word_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;

    if (state_q == IDLE && req) begin
      if (!range_err) begin
        is_wr_d     = bus.wr_en;
        word_d      = req_word;
        wdata_hi_d  = bus.write_data[WORD_W-1:SRAM_DATA_W];
        sram_addr_d = {req_word, 1'b0};
        dq_out_d    = bus.write_data[SRAM_DATA_W-1:0];
      end else if (!bus.wr_en) begin
        rdata_d = '0;
      end
    end

    if (state_q == LO && phase_tc) begin
      sram_addr_d = {word_q, 1'b1};
      dq_out_d    = wdata_hi_q;
      if (!is_wr_q) rdata_d[SRAM_DATA_W-1:0] = sram_dq_in;
    end

    if (state_q == HI && phase_tc && !is_wr_q) begin
      rdata_d[WORD_W-1:SRAM_DATA_W] = sram_dq_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_hi_q  <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
    end else begin
      is_wr_q     <= is_wr_d;
      word_q      <= word_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign bus.read_data = rdata_q;
  assign sram_addr     = sram_addr_q;
  assign sram_dq_out   = dq_out_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a behavioural SRAM and a completion scoreboard.
module tb_sram_mem_controller;

  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;

  typedef struct {
    logic [31:0] rd_data;
    int          latency;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  logic [15:0] mem [256];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  sram_mem_controller_if bus_if ();

  sram_mem_controller #(
    .WAIT_CYCLES (W),
    .ADDR_BASE   (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  // Asynchronous SRAM model: write commits on the rising edge of the strobe.
  always @(posedge sram_we_n) begin
    if (rst === 1'b1 && !$isunknown(sram_addr)) mem[sram_addr[7:0]] = sram_dq_out;
  end

  assign sram_dq_in = sram_oe_n ? 16'hA5A5 : mem[sram_addr[7:0]];

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_pins(input string tag);
    check({tag, ":we_n"},  {31'd0, sram_we_n},  32'd1);
    check({tag, ":oe_n"},  {31'd0, sram_oe_n},  32'd1);
    check({tag, ":dq_oe"}, {31'd0, sram_dq_oe}, 32'd0);
  endtask

  task automatic drop_req();
    bus_if.rd_en = 1'b0;
    bus_if.wr_en = 1'b0;
  endtask

  // One full access starting at the next cycle; expected pins per cycle come from the bench timeline.
  task automatic run_access(input string tag, input bit wr, input bit rd,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [16:0] exp_word, input logic [31:0] exp_rd,
                            input bit keep_req);
    exp_t e;
    bit   done;
    bit   half;
    bit   last;
    bit   is_wr;
    is_wr = wr;
    @(posedge clk); #1;
    bus_if.wr_en      = wr;
    bus_if.rd_en      = rd;
    bus_if.address    = addr;
    bus_if.write_data = data;
    #1;
    check({tag, ":c0_ready"}, {31'd0, bus_if.ready}, 32'd0);
    check_idle_pins({tag, ":c0"});
    sb.push_back('{exp_rd, 2 * W + 1});
    done = 1'b0;
    for (int c = 1; c <= 4 * W && !done; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        bus_if.address    = 32'hFFFF_FFF0;
        bus_if.write_data = 32'h0000_0000;
      end
      if (bus_if.ready === 1'b1) begin
        e = sb.pop_front();
        check({tag, ":latency"},   32'(c), 32'(e.latency));
        check({tag, ":read_data"}, bus_if.read_data, e.rd_data);
        check_idle_pins({tag, ":done"});
        if (!keep_req) drop_req();
        done = 1'b1;
      end else if (c <= 2 * W) begin
        half = (c > W);
        last = (((c - 1) % W) == W - 1);
        check($sformatf("%s:c%0d_addr", tag, c), {14'd0, sram_addr}, {14'd0, exp_word, half});
        if (is_wr) begin
          check($sformatf("%s:c%0d_dq_oe", tag, c), {31'd0, sram_dq_oe}, 32'd1);
          check($sformatf("%s:c%0d_we_n", tag, c),  {31'd0, sram_we_n},  {31'd0, last});
          check($sformatf("%s:c%0d_oe_n", tag, c),  {31'd0, sram_oe_n},  32'd1);
          check($sformatf("%s:c%0d_dq", tag, c), {16'd0, sram_dq_out},
                {16'd0, (half ? data[31:16] : data[15:0])});
        end else begin
          check($sformatf("%s:c%0d_oe_n", tag, c),  {31'd0, sram_oe_n},  32'd0);
          check($sformatf("%s:c%0d_dq_oe", tag, c), {31'd0, sram_dq_oe}, 32'd0);
          check($sformatf("%s:c%0d_we_n", tag, c),  {31'd0, sram_we_n},  32'd1);
        end
      end
    end
    check({tag, ":completed"}, {31'd0, done}, 32'd1);
    if (!done) begin
      drop_req();
      void'(sb.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst               = 1'b0;
    bus_if.rd_en      = 1'b0;
    bus_if.wr_en      = 1'b0;
    bus_if.address    = 32'd0;
    bus_if.write_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst:ready",     {31'd0, bus_if.ready},    32'd1);
    check("rst:read_data", bus_if.read_data,         32'd0);
    check("rst:addr_err",  {31'd0, bus_if.addr_err}, 32'd0);
    check("rst:sram_addr", {14'd0, sram_addr},       32'd0);
    check("rst:dq_out",    {16'd0, sram_dq_out},     32'd0);
    check_idle_pins("rst");
    rst = 1'b1;

    run_access("wr1028", 1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 17'd1, 32'h0000_0000, 1'b0);
    run_access("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0,         17'd0, 32'h0000_0000, 1'b1);
    run_access("rd1028", 1'b0, 1'b1, 32'd1028, 32'h0,         17'd1, 32'hDEAD_BEEF, 1'b0);
    run_access("rdwr1024", 1'b1, 1'b1, 32'd1024, 32'h1234_5678, 17'd0, 32'hDEAD_BEEF, 1'b0);
    run_access("rd1024b", 1'b0, 1'b1, 32'd1024, 32'h0,        17'd0, 32'h1234_5678, 1'b0);

    // Reset in the middle of a write's low phase.
    @(posedge clk); #1;
    bus_if.wr_en      = 1'b1;
    bus_if.address    = 32'd1028;
    bus_if.write_data = 32'hCAFE_F00D;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst:we_n_before", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    check_idle_pins("midrst");
    check("midrst:sram_addr", {14'd0, sram_addr}, 32'd0);
    check("midrst:read_data", bus_if.read_data,   32'd0);
    check("midrst:ready_req", {31'd0, bus_if.ready}, 32'd0);
    drop_req();
    #1;
    check("midrst:ready_idle", {31'd0, bus_if.ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    run_access("wr1032", 1'b1, 1'b0, 32'd1032, 32'h0BAD_CAFE, 17'd2, 32'h0000_0000, 1'b0);
    run_access("rd1032", 1'b0, 1'b1, 32'd1032, 32'h0,         17'd2, 32'h0BAD_CAFE, 1'b0);

`ifdef SRAM_ADDR_CHECK_EN
    @(posedge clk); #1;
    bus_if.rd_en   = 1'b1;
    bus_if.address = 32'd16;
    #1;
    check("oor:c0_ready", {31'd0, bus_if.ready}, 32'd0);
    @(posedge clk); #1;
    check("oor:c1_ready",     {31'd0, bus_if.ready},    32'd1);
    check("oor:c1_read_data", bus_if.read_data,         32'd0);
    check("oor:c1_addr_err",  {31'd0, bus_if.addr_err}, 32'd1);
    check_idle_pins("oor:c1");
    drop_req();
    for (int c = 2; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("oor:c%0d_addr_err", c), {31'd0, bus_if.addr_err}, 32'd1);
      check_idle_pins($sformatf("oor:c%0d", c));
    end
`else
    check("end:addr_err", {31'd0, bus_if.addr_err}, 32'd0);
`endif

    check("end:sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Responder for the MEM-stage memory request (rd_en/wr_en, address, write data) that the pipeline registers carry down from ID/EXE.
- Maps each 32-bit word access onto a 16-bit asynchronous SRAM as two half-word accesses, low half then high half.
- Holds ready low while busy so the pipeline freezes all stage registers until the access completes.

Parameters:
- WAIT_CYCLES, 5: clock cycles each half-word phase is held on the SRAM pins; legal range 2..15.
- ADDR_BASE, 1024: byte address that maps to SRAM word 0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rd_en  in  1  read request from MEM stage, held until ready
- wr_en  in  1  write request from MEM stage, held until ready
- address  in  32  byte address; bits [1:0] are ignored
- write_data  in  32  store data
- read_data  out  32  load data
- ready  out  1  1 = no access pending or access completing this cycle; 0 = freeze pipeline
- addr_err  out  1  sticky out-of-range flag (optional feature)
- sram_addr  out  18  SRAM half-word address
- sram_dq_out  out  16  data driven to SRAM
- sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus
- sram_dq_in  in  16  data sampled from SRAM
- sram_we_n  out  1  active-low SRAM write strobe
- sram_oe_n  out  1  active-low SRAM output enable

Behaviour:
- Address: off = address - ADDR_BASE; sram_addr = {off[18:2], half}, where half = 0 for the low phase and 1 for the high phase.
- States:
  - IDLE
  - LO: half 0
  - HI: half 1
  - DONE
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - Any request goes to LO next edge; the wait counter loads 0.
  - wr_en has priority when both are set; the access is treated as a write.
- LO / HI:
  - The counter increments each cycle.
  - On count == WAIT_CYCLES-1, LO -> HI or HI -> DONE, and the counter clears.
  - ready = 0 throughout.
- Write phases:
  - sram_dq_oe = 1.
  - sram_dq_out = write_data[15:0] in LO, write_data[31:16] in HI.
  - sram_we_n = 0 on all phase cycles except the last, giving address/data hold on the strobe rising edge.
  - sram_oe_n = 1.
- Read phases:
  - sram_oe_n = 0, sram_dq_oe = 0, sram_we_n = 1.
  - On the last cycle of LO, sram_dq_in is registered into read_data[15:0]; on the last cycle of HI, into read_data[31:16].
- DONE:
  - ready = 1 for exactly one cycle, then next state is IDLE unconditionally.
  - The request still visible in DONE is the completed one and is not restarted.
- Latency: a request first seen in IDLE at cycle 0 gives ready = 1 at cycle 2*WAIT_CYCLES+1; with the default this is cycle 11.
- read_data holds its value until the next read completes; writes do not alter it.
- The request inputs are sampled only in IDLE. Changes to address or data mid-access are ignored because the values are latched on the IDLE->LO edge.
- Idle pins: sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, sram_addr holds its last value.
- Reset (rst low, any time, including mid-access): state = IDLE, counter = 0, read_data = 0, addr_err = 0, sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1, sram_oe_n = 1. An interrupted write leaves that SRAM word undefined.

Optional Feature:
- Macro: SRAM_ADDR_CHECK_EN.
- Defined: a request with address < ADDR_BASE or off >= 2^19 goes IDLE -> DONE directly.
  - No SRAM strobe is driven.
  - A read returns read_data = 0.
  - addr_err is set and stays set until reset.
- Undefined: addr_err is tied to 0 and no range check is made; the address wraps modulo the SRAM size.

Decomposition:
- Shared package sram_pkg:
  - state enum (IDLE, LO, HI, DONE)
  - SRAM_ADDR_W = 18, SRAM_DATA_W = 16, WORD_W = 32
  - default WAIT_CYCLES and ADDR_BASE constants
- One sub-module, sram_wait_counter: 4-bit counter with clear/enable and a terminal-count output at WAIT_CYCLES-1.

Test Plan:
- Write: wr_en, address = 1028, write_data = 0xDEADBEEF.
  - Expect sram_addr = 2 with dq 0xBEEF for 5 cycles, then sram_addr = 3 with dq 0xDEAD for 5 cycles.
  - sram_we_n low 4 of 5 cycles in each phase; ready low cycles 0-10, high at cycle 11.
- Read back: rd_en, address = 1028, SRAM model returns the stored halves.
  - Expect read_data = 0xDEADBEEF at cycle 11 and sram_oe_n = 0 during LO/HI.
- Back-to-back: a read immediately after DONE.
  - Expect an IDLE cycle with ready = 0, a second full 11-cycle access, and no restart in DONE.
- Simultaneous rd_en = wr_en = 1 at address 1024, write_data = 0x12345678.
  - Expect write strobes only; read_data unchanged.
- Reset mid-access: rst low at cycle 3 of LO.
  - Expect immediate sram_we_n = 1, sram_dq_oe = 0, ready = 1 when idle.
  - After release, a fresh write completes in 11 cycles.
- With SRAM_ADDR_CHECK_EN: rd_en, address = 16.
  - Expect ready = 1 at cycle 1, read_data = 0, addr_err = 1 held, no SRAM strobes.
